// File: rtl/synth_param_loader.sv
// Byte-stream command parser for digital_synthesizer_v1: assembles 14-byte frames,
// validates sync/checksum/ranges and applies parameters atomically, re-arming the start level.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_HUNT  | discard bytes until SYNC_BYTE
// S_RECV  | collect b1..b13 into shadow registers, watch idle timeout
// S_CHECK | checksum and range verdict (one cycle)
// S_APPLY | copy shadow registers to outputs, pulse FRAME_OK (one cycle)
// S_GAP   | hold SIGN_START_GEN low for GAP_CYC cycles before re-arming
module synth_param_loader #(
   parameter int         TIMEOUT_CYC = 1000,
   parameter int         GAP_CYC     = 4,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  IN_DATA,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic        SIGN_START_GEN,
   output logic [1:0]  SIGNAL_TYPE,
   output logic [31:0] F_CARRIER,
   output logic [9:0]  T_IMPULSE,
   output logic [12:0] T_PERIOD,
   output logic [4:0]  NUM_OF_IMP,
   output logic [21:0] DEVIATION,
   output logic        FRAME_OK,
   output logic        FRAME_ERR,
   output logic [1:0]  ERR_CODE
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W  = $clog2(GAP_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYC - 1);
   localparam logic [31:0] F_CARRIER_MAX = 32'd4_200_000_000;

   typedef enum logic [2:0] {S_HUNT, S_RECV, S_CHECK, S_APPLY, S_GAP} state_t;

   state_t             state;
   logic [3:0]         byte_idx;
   logic [7:0]         xor_acc;
   logic [IDLE_W-1:0]  idle_cnt;
   logic [GAP_W-1:0]   gap_cnt;

   logic [1:0]  sh_type;
   logic [4:0]  sh_num;
   logic [31:0] sh_fc;
   logic [9:0]  sh_timp;
   logic [12:0] sh_tper;
   logic [21:0] sh_dev;

   logic xfer;
   logic range_bad;

   assign IN_READY  = (state == S_HUNT) || (state == S_RECV);
   assign xfer      = IN_VALID && IN_READY;
   assign range_bad = (sh_timp == 10'd0) || ({3'b000, sh_timp} > sh_tper) ||
                      (sh_fc > F_CARRIER_MAX);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= S_HUNT;
         byte_idx       <= 4'd0;
         xor_acc        <= 8'd0;
         idle_cnt       <= '0;
         gap_cnt        <= '0;
         sh_type        <= 2'd0;
         sh_num         <= 5'd0;
         sh_fc          <= 32'd0;
         sh_timp        <= 10'd0;
         sh_tper        <= 13'd0;
         sh_dev         <= 22'd0;
         SIGN_START_GEN <= 1'b0;
         SIGNAL_TYPE    <= 2'd0;
         F_CARRIER      <= 32'd0;
         T_IMPULSE      <= 10'd0;
         T_PERIOD       <= 13'd0;
         NUM_OF_IMP     <= 5'd0;
         DEVIATION      <= 22'd0;
         FRAME_OK       <= 1'b0;
         FRAME_ERR      <= 1'b0;
         ERR_CODE       <= 2'd0;
      end else begin
         FRAME_OK  <= 1'b0;
         FRAME_ERR <= 1'b0;
         case (state)
            S_HUNT: begin
               if (xfer && (IN_DATA == SYNC_BYTE)) begin
                  state    <= S_RECV;
                  byte_idx <= 4'd1;
                  xor_acc  <= 8'd0;
                  idle_cnt <= IDLE_LOAD;
               end
            end
            S_RECV: begin
               if (xfer) begin
                  xor_acc  <= xor_acc ^ IN_DATA;
                  idle_cnt <= IDLE_LOAD;
                  case (byte_idx)
                     4'd1:  begin sh_type <= IN_DATA[1:0]; sh_num <= IN_DATA[6:2]; end
                     4'd2:  sh_fc[31:24]   <= IN_DATA;
                     4'd3:  sh_fc[23:16]   <= IN_DATA;
                     4'd4:  sh_fc[15:8]    <= IN_DATA;
                     4'd5:  sh_fc[7:0]     <= IN_DATA;
                     4'd6:  sh_timp[9:8]   <= IN_DATA[1:0];
                     4'd7:  sh_timp[7:0]   <= IN_DATA;
                     4'd8:  sh_tper[12:8]  <= IN_DATA[4:0];
                     4'd9:  sh_tper[7:0]   <= IN_DATA;
                     4'd10: sh_dev[21:16]  <= IN_DATA[5:0];
                     4'd11: sh_dev[15:8]   <= IN_DATA;
                     4'd12: sh_dev[7:0]    <= IN_DATA;
                     default: ;
                  endcase
                  if (byte_idx == 4'd13) state <= S_CHECK;
                  else                   byte_idx <= byte_idx + 4'd1;
               end else if (idle_cnt == '0) begin
                  FRAME_ERR <= 1'b1;
                  ERR_CODE  <= 2'd3;
                  state     <= S_HUNT;
               end else begin
                  idle_cnt <= idle_cnt - 1'b1;
               end
            end
            S_CHECK: begin
               // xor_acc covers b1..b13, so a consistent frame folds to zero
               if (xor_acc != 8'd0) begin
                  FRAME_ERR <= 1'b1;
                  ERR_CODE  <= 2'd1;
                  state     <= S_HUNT;
               end else if ((sh_type != 2'd0) && range_bad) begin
                  FRAME_ERR <= 1'b1;
                  ERR_CODE  <= 2'd2;
                  state     <= S_HUNT;
               end else begin
                  state <= S_APPLY;
               end
            end
            S_APPLY: begin
               FRAME_OK   <= 1'b1;
               ERR_CODE   <= 2'd0;
               F_CARRIER  <= sh_fc;
               T_IMPULSE  <= sh_timp;
               T_PERIOD   <= sh_tper;
               NUM_OF_IMP <= sh_num;
               DEVIATION  <= sh_dev;
               if (sh_type == 2'd0) begin
                  SIGN_START_GEN <= 1'b0;
                  state          <= S_HUNT;
               end else begin
                  SIGNAL_TYPE <= sh_type;
                  if (SIGN_START_GEN) begin
                     SIGN_START_GEN <= 1'b0;
                     gap_cnt        <= GAP_LOAD;
                     state          <= S_GAP;
                  end else begin
                     SIGN_START_GEN <= 1'b1;
                     state          <= S_HUNT;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  SIGN_START_GEN <= 1'b1;
                  state          <= S_HUNT;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= S_HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_synth_param_loader.sv
// Self-checking bench for synth_param_loader: frame-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized frames.
module tb_synth_param_loader;

   localparam int         TIMEOUT_CYC = 1000;
   localparam int         GAP_CYC     = 4;
   localparam logic [7:0] SYNC        = 8'hA5;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [7:0]  IN_DATA = 8'd0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY, SIGN_START_GEN, FRAME_OK, FRAME_ERR;
   logic [1:0]  SIGNAL_TYPE, ERR_CODE;
   logic [31:0] F_CARRIER;
   logic [9:0]  T_IMPULSE;
   logic [12:0] T_PERIOD;
   logic [4:0]  NUM_OF_IMP;
   logic [21:0] DEVIATION;

   synth_param_loader #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC), .SYNC_BYTE(SYNC)) u_dut (
      .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .SIGN_START_GEN(SIGN_START_GEN), .SIGNAL_TYPE(SIGNAL_TYPE), .F_CARRIER(F_CARRIER),
      .T_IMPULSE(T_IMPULSE), .T_PERIOD(T_PERIOD), .NUM_OF_IMP(NUM_OF_IMP),
      .DEVIATION(DEVIATION), .FRAME_OK(FRAME_OK), .FRAME_ERR(FRAME_ERR), .ERR_CODE(ERR_CODE)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_acc = 0;
   bit chk_en = 0;

   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic        m_ready = 1'b1, m_start = 1'b0, m_ok = 1'b0, m_err = 1'b0;
   logic [1:0]  m_type = 2'd0, m_code = 2'd0;
   logic [31:0] m_fc = 32'd0;
   logic [9:0]  m_timp = 10'd0;
   logic [12:0] m_tper = 13'd0;
   logic [4:0]  m_num = 5'd0;
   logic [21:0] m_dev = 22'd0;
   bit          in_frame = 0;
   logic [7:0]  fbytes[$];
   int          idle = 0, busy_t = 0, gap_left = 0;
   bit          v_bad;
   logic [1:0]  v_code, p_type;
   logic [4:0]  p_num;
   logic [31:0] p_fc;
   logic [9:0]  p_timp;
   logic [12:0] p_tper;
   logic [21:0] p_dev;

   task automatic judge();
      logic [7:0]  x;
      logic [15:0] w16;
      logic [23:0] w24;
      x = 8'd0;
      foreach (fbytes[i]) x = x ^ fbytes[i];
      p_type = fbytes[0][1:0];
      p_num  = fbytes[0][6:2];
      p_fc   = {fbytes[1], fbytes[2], fbytes[3], fbytes[4]};
      w16 = {fbytes[5], fbytes[6]};  p_timp = w16[9:0];
      w16 = {fbytes[7], fbytes[8]};  p_tper = w16[12:0];
      w24 = {fbytes[9], fbytes[10], fbytes[11]}; p_dev = w24[21:0];
      v_bad = 1; v_code = 2'd1;
      if (x != 8'd0) v_code = 2'd1;
      else if (p_type != 0 && (p_timp == 0 || p_tper < p_timp || p_fc > 32'd4_200_000_000))
         v_code = 2'd2;
      else v_bad = 0;
   endtask

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_ready = 1; m_start = 0; m_ok = 0; m_err = 0; m_type = 0; m_code = 0;
         m_fc = 0; m_timp = 0; m_tper = 0; m_num = 0; m_dev = 0;
         in_frame = 0; idle = 0; busy_t = 0; gap_left = 0;
      end else begin
         m_ok = 0; m_err = 0;
         if (!m_ready) begin
            busy_t++;
            if (busy_t == 1 && v_bad) begin
               m_err = 1; m_code = v_code; m_ready = 1;
            end else if (busy_t == 2) begin
               m_ok = 1; m_code = 0;
               m_fc = p_fc; m_timp = p_timp; m_tper = p_tper; m_num = p_num; m_dev = p_dev;
               if (p_type == 0) begin
                  m_start = 0; m_ready = 1;
               end else begin
                  m_type = p_type;
                  if (m_start) begin m_start = 0; gap_left = GAP_CYC; end
                  else begin m_start = 1; m_ready = 1; end
               end
            end else if (busy_t > 2) begin
               gap_left--;
               if (gap_left == 0) begin m_start = 1; m_ready = 1; end
            end
         end else if (!in_frame) begin
            if (IN_VALID && IN_DATA == SYNC) begin in_frame = 1; fbytes.delete(); idle = 0; end
         end else if (IN_VALID) begin
            fbytes.push_back(IN_DATA);
            idle = 0;
            if (fbytes.size() == 13) begin
               judge(); in_frame = 0; m_ready = 0; busy_t = 0;
            end
         end else begin
            idle++;
            if (idle == TIMEOUT_CYC) begin m_err = 1; m_code = 2'd3; in_frame = 0; end
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("IN_READY", IN_READY, m_ready);
         chk("SIGN_START_GEN", SIGN_START_GEN, m_start);
         chk("SIGNAL_TYPE", SIGNAL_TYPE, m_type);
         chk("F_CARRIER", F_CARRIER, m_fc);
         chk("T_IMPULSE", T_IMPULSE, m_timp);
         chk("T_PERIOD", T_PERIOD, m_tper);
         chk("NUM_OF_IMP", NUM_OF_IMP, m_num);
         chk("DEVIATION", DEVIATION, m_dev);
         chk("FRAME_OK", FRAME_OK, m_ok);
         chk("FRAME_ERR", FRAME_ERR, m_err);
         chk("ERR_CODE", ERR_CODE, m_code);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] fr [14];

   task automatic mk_frame(input logic [1:0] typ, input logic [4:0] num, input logic [31:0] fc,
                           input logic [15:0] timp, input logic [15:0] tper, input logic [23:0] dev);
      fr[0] = SYNC;             fr[1] = {1'b0, num, typ};
      fr[2] = fc[31:24];        fr[3] = fc[23:16];  fr[4] = fc[15:8];  fr[5] = fc[7:0];
      fr[6] = timp[15:8];       fr[7] = timp[7:0];
      fr[8] = tper[15:8];       fr[9] = tper[7:0];
      fr[10] = dev[23:16];      fr[11] = dev[15:8]; fr[12] = dev[7:0];
      fr[13] = 8'd0;
      for (int i = 1; i <= 12; i++) fr[13] = fr[13] ^ fr[i];
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      bit rdy;
      n = 0;
      IN_DATA = b;
      IN_VALID = 1;
      forever begin
         rdy = IN_READY;
         @(negedge CLK);
         if (rdy) break;
         n++;
         if (n > 100) begin
            fails++; tests++;
            $display("FAIL byte_accept_wait actual=stalled required=accepted");
            break;
         end
      end
      last_acc = cyc;
      IN_VALID = 0;
      IN_DATA = $urandom_range(0, 255);
      if (gap) repeat ($urandom_range(0, 2)) @(negedge CLK);
   endtask

   task automatic send_frame();
      for (int i = 0; i < 14; i++) send_byte(fr[i], i != 13);
   endtask

   task automatic wait_pulse(input bit want_ok, input int limit);
      int n;
      n = 0;
      while (!(want_ok ? FRAME_OK : FRAME_ERR) && n < limit) begin
         @(negedge CLK);
         n++;
      end
      tests++;
      if (n >= limit) begin
         fails++;
         $display("FAIL wait_%s actual=no_pulse required=pulse", want_ok ? "ok" : "err");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lowc, rdy_viol;
      logic [31:0] fc_r;
      logic [15:0] ti_r, tp_r;
      RESET = 0;
      repeat (3) @(negedge CLK);
      chk("rst_ready", IN_READY, 1);
      chk("rst_start", SIGN_START_GEN, 0);
      chk("rst_fc", F_CARRIER, 0);
      chk("rst_err_code", ERR_CODE, 0);
      chk_en = 1;
      #2 RESET = 1;
      @(negedge CLK);

      // noise frame from idle
      mk_frame(2'd3, 5'd1, 32'd1_300_000_000, 16'd10, 16'd20, 24'd3_000_000);
      send_frame();
      wait_pulse(1, 20);
      chk("ok_latency", cyc - last_acc, 2);
      chk("noise_fc", F_CARRIER, 32'd1_300_000_000);
      chk("noise_timp", T_IMPULSE, 10);
      chk("noise_tper", T_PERIOD, 20);
      chk("noise_num", NUM_OF_IMP, 1);
      chk("noise_type", SIGNAL_TYPE, 3);
      chk("noise_dev", DEVIATION, 24'd3_000_000);
      @(negedge CLK);
      chk("noise_start", SIGN_START_GEN, 1);

      // LFM while running: re-arm gap
      mk_frame(2'd1, 5'd1, 32'd1_300_000_000, 16'd10, 16'd20, 24'd2_000_000);
      send_frame();
      wait_pulse(1, 20);
      chk("lfm_dev", DEVIATION, 24'd2_000_000);
      chk("lfm_type", SIGNAL_TYPE, 1);
      lowc = 0; rdy_viol = 0;
      while (SIGN_START_GEN == 0 && lowc < 20) begin
         if (IN_READY) rdy_viol++;
         lowc++;
         @(negedge CLK);
      end
      chk("gap_low_cycles", lowc, GAP_CYC);
      chk("gap_ready_low", rdy_viol, 0);

      // bad checksum
      fr[13] = fr[13] ^ 8'h01;
      send_frame();
      wait_pulse(0, 20);
      chk("csum_err_code", ERR_CODE, 1);
      chk("csum_dev_kept", DEVIATION, 24'd2_000_000);
      chk("csum_start_kept", SIGN_START_GEN, 1);

      // range failure: period shorter than pulse
      mk_frame(2'd1, 5'd2, 32'd1_000_000, 16'd10, 16'd5, 24'd77);
      send_frame();
      wait_pulse(0, 20);
      chk("range_err_code", ERR_CODE, 2);
      chk("range_tper_kept", T_PERIOD, 20);

      // timeout after 6 bytes, then garbage + valid PSK frame
      mk_frame(2'd2, 5'd7, 32'd900_000_000, 16'd50, 16'd200, 24'd1_000_000);
      for (int i = 0; i < 6; i++) send_byte(fr[i], i != 5);
      wait_pulse(0, TIMEOUT_CYC + 50);
      chk("timeout_code", ERR_CODE, 3);
      chk("timeout_latency", cyc - last_acc, TIMEOUT_CYC);
      send_byte(8'h00, 1);
      send_byte(8'h12, 1);
      send_frame();
      wait_pulse(1, 20);
      chk("psk_type", SIGNAL_TYPE, 2);
      chk("psk_fc", F_CARRIER, 32'd900_000_000);
      chk("psk_err_code_cleared", ERR_CODE, 0);

      // stop frame: only checksum matters, type kept
      mk_frame(2'd0, 5'd3, 32'd5, 16'd0, 16'd0, 24'd0);
      send_frame();
      wait_pulse(1, 40);
      chk("stop_start", SIGN_START_GEN, 0);
      chk("stop_type_kept", SIGNAL_TYPE, 2);
      chk("stop_fc", F_CARRIER, 5);

      // randomized frames
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 2)) begin
            logic [7:0] g;
            g = $urandom_range(0, 255);
            if (g == SYNC) g = 8'h5A;
            send_byte(g, 1);
         end
         if ($urandom_range(0, 1) == 0) begin
            ti_r = $urandom_range(1, 1023);
            tp_r = $urandom_range(int'(ti_r), 8191);
            fc_r = $urandom_range(0, 32'd4_200_000_000);
         end else begin
            ti_r = $urandom; tp_r = $urandom; fc_r = $urandom;
         end
         mk_frame($urandom_range(0, 3), $urandom_range(0, 31), fc_r, ti_r, tp_r, $urandom);
         if ($urandom_range(0, 4) == 0) fr[1 + $urandom_range(0, 12)] ^= 8'h10;
         send_frame();
      end
      repeat (20) @(negedge CLK);

      // reset in the middle of a frame while running
      mk_frame(2'd3, 5'd4, 32'd10_000, 16'd3, 16'd9, 24'd5);
      send_frame();
      repeat (20) @(negedge CLK);
      chk("pre_reset_start", SIGN_START_GEN, 1);
      for (int i = 0; i < 4; i++) send_byte(fr[i], 0);
      #2 RESET = 0;
      #1;
      chk("midrst_ready", IN_READY, 1);
      chk("midrst_start", SIGN_START_GEN, 0);
      chk("midrst_fc", F_CARRIER, 0);
      chk("midrst_type", SIGNAL_TYPE, 0);
      chk("midrst_dev", DEVIATION, 0);
      repeat (2) @(negedge CLK);
      #2 RESET = 1;
      @(negedge CLK);
      send_frame();
      wait_pulse(1, 20);
      chk("post_reset_fc", F_CARRIER, 32'd10_000);
      repeat (5) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
